// File: rtl/block_mul_dispatcher.sv
// Round-robin dispatcher that issues 2x2 block-multiply jobs to NUM_UNITS units and returns tagged completions.
// Define IN_ORDER_EN to force results to leave in issue order (FIFO of issued unit indices).
module block_mul_dispatcher #(
    parameter int NUM_UNITS = 3,
    parameter int UNIT_W    = 2,
    parameter int TAG_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [TAG_W-1:0]     job_tag,
    output logic [NUM_UNITS-1:0] unit_start,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_ack,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [TAG_W-1:0]     res_tag,
    output logic [UNIT_W-1:0]    res_unit,
    output logic                 all_idle,
    output logic                 err
);

    typedef enum logic [1:0] {
        UNIT_IDLE = 2'd0,
        UNIT_RUN  = 2'd1
    } unit_state_e;

    unit_state_e            state_q [NUM_UNITS];
    unit_state_e            state_d [NUM_UNITS];
    logic [TAG_W-1:0]       tag_q   [NUM_UNITS];
    logic [TAG_W-1:0]       tag_d   [NUM_UNITS];
    logic [UNIT_W-1:0]      issue_ptr_q, issue_ptr_d;
    logic [NUM_UNITS-1:0]   unit_start_q, unit_start_d;
    logic [NUM_UNITS-1:0]   unit_ack_q, unit_ack_d;
    logic                   res_valid_q, res_valid_d;
    logic [TAG_W-1:0]       res_tag_q, res_tag_d;
    logic [UNIT_W-1:0]      res_unit_q, res_unit_d;
    logic                   err_q, err_d;

    logic [NUM_UNITS-1:0]   idle_vec;
    logic [NUM_UNITS-1:0]   elig_vec;
    logic [UNIT_W-1:0]      done_base;
    logic                   issue_fire;
    logic                   issue_found;
    logic                   done_found;
    logic                   load_ok;
    int                     issue_idx;
    int                     done_idx;
    int                     scan_k;

`ifdef IN_ORDER_EN
    logic [UNIT_W-1:0]      fifo_q [NUM_UNITS];
    logic [UNIT_W-1:0]      fifo_d [NUM_UNITS];
    logic [UNIT_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [UNIT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [UNIT_W:0]        fifo_cnt_q, fifo_cnt_d;
    logic [UNIT_W-1:0]      fifo_head;
`else
    logic [UNIT_W-1:0]      done_ptr_q, done_ptr_d;
`endif

    function automatic logic [UNIT_W-1:0] wrap_inc(input logic [UNIT_W-1:0] p);
        return (p == UNIT_W'(NUM_UNITS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            idle_vec[k] = (state_q[k] == UNIT_IDLE);
        end
    end

    assign job_ready = |idle_vec;
    assign all_idle  = (&idle_vec) && !res_valid_q;

    // In in-order mode only the oldest issued unit may complete, so the scan base is irrelevant.
    always_comb begin
        elig_vec  = '0;
        done_base = '0;
`ifdef IN_ORDER_EN
        fifo_head = fifo_q[rd_ptr_q];
        for (int k = 0; k < NUM_UNITS; k++) begin
            elig_vec[k] = (state_q[k] == UNIT_RUN) && unit_done[k] &&
                          (fifo_cnt_q != '0) && (fifo_head == UNIT_W'(k));
        end
`else
        done_base = done_ptr_q;
        for (int k = 0; k < NUM_UNITS; k++) begin
            elig_vec[k] = (state_q[k] == UNIT_RUN) && unit_done[k];
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        issue_ptr_d  = issue_ptr_q;
        unit_start_d = '0;
        unit_ack_d   = '0;
        res_valid_d  = res_valid_q;
        res_tag_d    = res_tag_q;
        res_unit_d   = res_unit_q;
        err_d        = err_q;
        issue_found  = 1'b0;
        issue_idx    = 0;
        done_found   = 1'b0;
        done_idx     = 0;
        scan_k       = 0;
`ifdef IN_ORDER_EN
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
`else
        done_ptr_d   = done_ptr_q;
`endif

        for (int i = 0; i < NUM_UNITS; i++) begin
            scan_k = (int'(issue_ptr_q) + i) % NUM_UNITS;
            if (!issue_found && idle_vec[scan_k]) begin
                issue_found = 1'b1;
                issue_idx   = scan_k;
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            scan_k = (int'(done_base) + i) % NUM_UNITS;
            if (!done_found && elig_vec[scan_k]) begin
                done_found = 1'b1;
                done_idx   = scan_k;
            end
        end

        issue_fire = job_valid && issue_found;
        if (issue_fire) begin
            state_d[issue_idx]      = UNIT_RUN;
            tag_d[issue_idx]        = job_tag;
            unit_start_d[issue_idx] = 1'b1;
            issue_ptr_d             = wrap_inc(UNIT_W'(issue_idx));
`ifdef IN_ORDER_EN
            fifo_d[wr_ptr_q]        = UNIT_W'(issue_idx);
            wr_ptr_d                = wrap_inc(wr_ptr_q);
`endif
        end

        // A unit returns to IDLE on the same edge that raises its ack, so it is reissuable next cycle.
        load_ok = !res_valid_q || res_ready;
        if (load_ok) begin
            if (done_found) begin
                res_valid_d          = 1'b1;
                res_tag_d            = tag_q[done_idx];
                res_unit_d           = UNIT_W'(done_idx);
                unit_ack_d[done_idx] = 1'b1;
                state_d[done_idx]    = UNIT_IDLE;
`ifdef IN_ORDER_EN
                rd_ptr_d             = wrap_inc(rd_ptr_q);
`else
                done_ptr_d           = wrap_inc(UNIT_W'(done_idx));
`endif
            end else begin
                res_valid_d = 1'b0;
            end
        end

`ifdef IN_ORDER_EN
        fifo_cnt_d = fifo_cnt_q + {{UNIT_W{1'b0}}, issue_fire}
                                - {{UNIT_W{1'b0}}, load_ok && done_found};
`endif

        // Done is still legitimately high during the ack cycle; anything else outside RUN is an error.
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_done[k] && (state_q[k] != UNIT_RUN) && !unit_ack_q[k]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                state_q[k] <= UNIT_IDLE;
                tag_q[k]   <= '0;
            end
            issue_ptr_q  <= '0;
            unit_start_q <= '0;
            unit_ack_q   <= '0;
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
            res_unit_q   <= '0;
            err_q        <= 1'b0;
`ifdef IN_ORDER_EN
            for (int k = 0; k < NUM_UNITS; k++) begin
                fifo_q[k] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
`else
            done_ptr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            issue_ptr_q  <= issue_ptr_d;
            unit_start_q <= unit_start_d;
            unit_ack_q   <= unit_ack_d;
            res_valid_q  <= res_valid_d;
            res_tag_q    <= res_tag_d;
            res_unit_q   <= res_unit_d;
            err_q        <= err_d;
`ifdef IN_ORDER_EN
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
`else
            done_ptr_q   <= done_ptr_d;
`endif
        end
    end

    assign unit_start = unit_start_q;
    assign unit_ack   = unit_ack_q;
    assign res_valid  = res_valid_q;
    assign res_tag    = res_tag_q;
    assign res_unit   = res_unit_q;
    assign err        = err_q;

endmodule

// File: tb/tb_block_mul_dispatcher.sv
// Bench for block_mul_dispatcher: directed scenarios plus randomized traffic against a job-level reference model.
// Simulated units raise done after a random latency and drop it after seeing their ack.
module tb_block_mul_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       job_valid;
    logic       job_ready;
    logic [7:0] job_tag;
    logic [2:0] unit_start;
    logic [2:0] unit_done;
    logic [2:0] unit_ack;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_tag;
    logic [1:0] res_unit;
    logic       all_idle;
    logic       err;

    int checks = 0;
    int errors = 0;

    block_mul_dispatcher #(.NUM_UNITS(3), .UNIT_W(2), .TAG_W(8)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
        .unit_start(unit_start), .unit_done(unit_done), .unit_ack(unit_ack),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_unit(res_unit),
        .all_idle(all_idle), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model: which units hold a job, their tags, and the result register.
    bit         m_busy [3];
    logic [7:0] m_tag  [3];
    int         m_issue_ptr, m_done_ptr;
    bit         m_rv;
    logic [7:0] m_rtag;
    int         m_runit;
    logic [2:0] m_start, m_ack;
    bit         m_err;
    int         m_order [$];

    // Simulated unit environment.
    bit auto_units;
    bit ack_seen [3];
    int lat_cnt  [3];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_tag[k] = '0; ack_seen[k] = 0; lat_cnt[k] = 0;
        end
        m_issue_ptr = 0; m_done_ptr = 0; m_rv = 0; m_rtag = '0; m_runit = 0;
        m_start = '0; m_ack = '0; m_err = 0;
        m_order.delete();
    endtask

    function automatic bit model_job_ready();
        bit r = 0;
        for (int k = 0; k < 3; k++) if (!m_busy[k]) r = 1;
        return r;
    endfunction

    function automatic bit model_all_idle();
        bit r = !m_rv;
        for (int k = 0; k < 3; k++) if (m_busy[k]) r = 0;
        return r;
    endfunction

    task automatic env_drive();
        for (int k = 0; k < 3; k++) begin
            if (ack_seen[k]) begin
                unit_done[k] = 1'b0;
                ack_seen[k]  = 0;
            end
            if (unit_ack[k]) ack_seen[k] = 1;
            if (auto_units) begin
                if (unit_start[k]) begin
                    lat_cnt[k] = $urandom_range(1, 4);
                end else if (lat_cnt[k] > 0) begin
                    lat_cnt[k]--;
                    if (lat_cnt[k] == 0) unit_done[k] = 1'b1;
                end
            end
        end
    endtask

    // One clock: predict from spec rules, advance, compare every output.
    task automatic step();
        int iss, cmp, k;
        bit ld, n_err;
        logic [7:0] tag_in;
        iss = -1;
        cmp = -1;
        if (job_valid && model_job_ready()) begin
            for (int i = 0; i < 3; i++) begin
                k = (m_issue_ptr + i) % 3;
                if (iss < 0 && !m_busy[k]) iss = k;
            end
        end
        ld = !m_rv || res_ready;
        if (ld) begin
`ifdef IN_ORDER_EN
            if (m_order.size() > 0 && m_busy[m_order[0]] && unit_done[m_order[0]]) cmp = m_order[0];
`else
            for (int i = 0; i < 3; i++) begin
                k = (m_done_ptr + i) % 3;
                if (cmp < 0 && m_busy[k] && unit_done[k]) cmp = k;
            end
`endif
        end
        n_err = m_err;
        for (int j = 0; j < 3; j++) if (unit_done[j] && !m_busy[j] && !m_ack[j]) n_err = 1;
        tag_in = job_tag;

        @(posedge clk);
        #1;
        m_start = '0;
        m_ack   = '0;
        m_err   = n_err;
        if (iss >= 0) begin
            m_busy[iss]  = 1;
            m_tag[iss]   = tag_in;
            m_start[iss] = 1'b1;
            m_issue_ptr  = (iss + 1) % 3;
`ifdef IN_ORDER_EN
            m_order.push_back(iss);
`endif
        end
        if (ld) begin
            if (cmp >= 0) begin
                m_rv       = 1;
                m_rtag     = m_tag[cmp];
                m_runit    = cmp;
                m_ack[cmp] = 1'b1;
                m_busy[cmp] = 0;
                m_done_ptr = (cmp + 1) % 3;
`ifdef IN_ORDER_EN
                void'(m_order.pop_front());
`endif
            end else begin
                m_rv = 0;
            end
        end

        check("job_ready", job_ready, model_job_ready());
        check("unit_start", unit_start, m_start);
        check("unit_ack", unit_ack, m_ack);
        check("res_valid", res_valid, m_rv);
        check("res_tag", res_tag, m_rtag);
        check("res_unit", res_unit, m_runit);
        check("all_idle", all_idle, model_all_idle());
        check("err", err, m_err);
        env_drive();
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        job_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = model_all_idle();
        end
        check(name, ok, 1);
    endtask

    initial begin
        reset = 1'b0; job_valid = 1'b0; job_tag = '0; unit_done = '0; res_ready = 1'b0;
        auto_units = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_unit_start", unit_start, 3'b000);
        check("rst_res_valid", res_valid, 0);
        check("rst_all_idle", all_idle, 1);
        check("rst_err", err, 0);
        reset = 1'b1;

        // Three back-to-back jobs fill all units in order.
        job_valid = 1'b1; job_tag = 8'h10; step(); check("issue0", unit_start, 3'b001);
        job_tag = 8'h11;                   step(); check("issue1", unit_start, 3'b010);
        job_tag = 8'h12;                   step(); check("issue2", unit_start, 3'b100);
        check("full_not_ready", job_ready, 0);

        // Fourth job waits until unit 1 frees.
        job_tag = 8'h13; step(); step();
        check("held_no_start", unit_start, 3'b000);
        unit_done[1] = 1'b1; res_ready = 1'b1;
        step();
        check("u1_res_tag", res_tag, 8'h11);
        check("u1_res_unit", res_unit, 2'd1);
        check("u1_ack", unit_ack, 3'b010);
        step();
        check("reissue_u1", unit_start, 3'b010);
        job_valid = 1'b0;

        // All units complete together; round-robin from unit 2.
        step();
        unit_done = 3'b111;
        step(); check("rr0_unit", res_unit, 2'd2); check("rr0_tag", res_tag, 8'h12);
        step(); check("rr1_unit", res_unit, 2'd0); check("rr1_tag", res_tag, 8'h10);
        step(); check("rr2_unit", res_unit, 2'd1); check("rr2_tag", res_tag, 8'h13);
        step(); check("rr_empty", res_valid, 0);

        // Sequencer stalls while another unit is waiting to complete.
        job_valid = 1'b1; job_tag = 8'h30; step();
        job_tag = 8'h31; step();
        job_valid = 1'b0; res_ready = 1'b0; unit_done = 3'b101;
        step(); check("stall_load_tag", res_tag, 8'h30);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_tag", res_tag, 8'h30);
            check("stall_no_ack", unit_ack, 3'b000);
        end
        res_ready = 1'b1;
        step(); check("b2b_tag", res_tag, 8'h31); check("b2b_unit", res_unit, 2'd0);
        drain("drain_directed");

        // Randomized traffic.
        auto_units = 1;
        for (int i = 0; i < 400; i++) begin
            job_valid = 1'($urandom_range(0, 1));
            job_tag   = 8'($urandom_range(0, 255));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("drain_random");

        // Spurious done on an idle unit is sticky and harmless to traffic.
        auto_units = 0;
        unit_done = 3'b100;
        step(); check("err_set", err, 1);
        unit_done = 3'b000;
        auto_units = 1;
        job_valid = 1'b1; job_tag = 8'h50; step();
        job_tag = 8'h51; step();
        drain("drain_after_err");
        check("err_sticky", err, 1);

        // Reset with two jobs in flight.
        auto_units = 0;
        job_valid = 1'b1; job_tag = 8'h40; step();
        job_tag = 8'h41; step();
        job_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        check("mid_rst_start", unit_start, 3'b000);
        check("mid_rst_ack", unit_ack, 3'b000);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_tag", res_tag, 8'h00);
        check("mid_rst_res_unit", res_unit, 2'd0);
        check("mid_rst_err", err, 0);
        check("mid_rst_all_idle", all_idle, 1);
        unit_done = '0;
        model_reset();
        @(negedge clk) reset = 1'b1;
        step();
        check("post_rst_all_idle", all_idle, 1);
        job_valid = 1'b1; job_tag = 8'h60; step();
        check("post_rst_issue_u0", unit_start, 3'b001);
        job_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
